// File: rtl/ysyx_2022040010_icache_refill_pkg.sv
// rtl/ysyx_2022040010_icache_refill_pkg.sv - AXI constants and state encoding for the icache refill engine
package ysyx_2022040010_icache_refill_pkg;

  // AXI burst and response codes used by the refill engine
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI transfer size codes for the two supported data widths
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

  // Refill engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_FILL = 2'd3
  } refill_state_e;

  // arsize code for a given AXI data width (32 or 64)
  function automatic logic [2:0] axi_size(input int dw);
    return (dw == 32) ? AXI_SIZE_4B : AXI_SIZE_8B;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_icache_refill.sv
// rtl/ysyx_2022040010_icache_refill.sv - AXI4 read-burst refill engine for the 2-way 8-byte-line icache
module ysyx_2022040010_icache_refill
  import ysyx_2022040010_icache_refill_pkg::*;
#(
  parameter int AXI_AW = 32,
  parameter int AXI_DW = 64
) (
  input  logic              clk,
  input  logic              rst,
  // miss request from icache control
  input  logic              miss_req,
  input  logic [63:0]       miss_addr,
  input  logic              miss_cache,
  input  logic              miss_lru,
  output logic              miss_ready,
  // data/tag array write port
  output logic              refresh,
  output logic              refill_way,
  output logic [63:0]       cacheline_new,
  // fetch-stage response
  output logic              resp_valid,
  output logic [31:0]       resp_inst,
  output logic              resp_err,
  // AXI AR channel
  output logic              arvalid,
  input  logic              arready,
  output logic [AXI_AW-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  // AXI R channel
  input  logic              rvalid,
  output logic              rready,
  input  logic [AXI_DW-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
);

  localparam int BEATS = 64 / AXI_DW;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [2:0]     AR_SIZE   = axi_size(AXI_DW);

  refill_state_e     state_q, state_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic              cache_q, cache_d;
  logic              way_q, way_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic [63:0]       line_q, line_d;

  logic is_last_beat;
  logic fill;

  // Only bit 2 of the latched address matters below the line boundary
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[1:0];

  assign is_last_beat = (beat_cnt_q == LAST_BEAT);

  // Next-state, request latching, beat assembly and error accumulation
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cache_d    = cache_q;
    way_d      = way_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    line_d     = line_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          state_d    = ST_AR;
          addr_d     = AXI_AW'(miss_addr);
          cache_d    = miss_cache;
          way_d      = miss_lru;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          line_d     = '0;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        // rready is high throughout R, so rvalid alone marks a handshake
        if (rvalid) begin
          for (int i = 0; i < BEATS; i++) begin
            if (beat_cnt_q == BCW'(i)) begin
              line_d[i*AXI_DW +: AXI_DW] = rdata;
            end
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Bad response, early rlast or missing rlast all poison the line
          if ((rresp != AXI_RESP_OKAY) || (rlast != is_last_beat)) begin
            err_d = 1'b1;
          end
          // The final beat slot closes the burst even without rlast
          if (rlast || is_last_beat) begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cache_q    <= 1'b0;
      way_q      <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cache_q    <= cache_d;
      way_q      <= way_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      line_q     <= line_d;
    end
  end

  // Outputs decoded from state and registers only
  assign fill          = (state_q == ST_FILL);
  assign miss_ready    = (state_q == ST_IDLE);
  assign arvalid       = (state_q == ST_AR);
  assign rready        = (state_q == ST_R);
  assign araddr        = {addr_q[AXI_AW-1:3], 3'b000};
  assign arid          = 4'd0;
  assign arlen         = 8'(BEATS - 1);
  assign arsize        = AR_SIZE;
  assign arburst       = AXI_BURST_INCR;
  assign resp_valid    = fill;
  assign resp_err      = fill & err_q;
  assign refresh       = fill & cache_q & ~err_q;
  assign refill_way    = way_q;
  assign cacheline_new = line_q;
  assign resp_inst     = (fill && !err_q) ? (addr_q[2] ? line_q[63:32] : line_q[31:0]) : 32'd0;

endmodule

// File: tb/tb_ysyx_2022040010_icache_refill.sv
// tb/tb_ysyx_2022040010_icache_refill.sv - randomized self-checking bench for the icache refill engine
module tb_ysyx_2022040010_icache_refill;

  logic clk;
  logic rst;

  // Per-instance handshake inputs; index 0 is AXI_DW=64, index 1 is AXI_DW=32
  logic        miss_req [2];
  logic        arready  [2];
  logic        rvalid   [2];
  logic [63:0] m_addr;
  logic        m_cache;
  logic        m_lru;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  logic        miss_ready_o [2];
  logic        refresh_o    [2];
  logic        refill_way_o [2];
  logic [63:0] line_o       [2];
  logic        resp_valid_o [2];
  logic [31:0] resp_inst_o  [2];
  logic        resp_err_o   [2];
  logic        arvalid_o    [2];
  logic [31:0] araddr_o     [2];
  logic [3:0]  arid_o       [2];
  logic [7:0]  arlen_o      [2];
  logic [2:0]  arsize_o     [2];
  logic [1:0]  arburst_o    [2];
  logic        rready_o     [2];

  ysyx_2022040010_icache_refill #(.AXI_AW(32), .AXI_DW(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .miss_req(miss_req[0]), .miss_addr(m_addr), .miss_cache(m_cache), .miss_lru(m_lru),
    .miss_ready(miss_ready_o[0]), .refresh(refresh_o[0]), .refill_way(refill_way_o[0]),
    .cacheline_new(line_o[0]), .resp_valid(resp_valid_o[0]), .resp_inst(resp_inst_o[0]),
    .resp_err(resp_err_o[0]), .arvalid(arvalid_o[0]), .arready(arready[0]),
    .araddr(araddr_o[0]), .arid(arid_o[0]), .arlen(arlen_o[0]), .arsize(arsize_o[0]),
    .arburst(arburst_o[0]), .rvalid(rvalid[0]), .rready(rready_o[0]),
    .rdata(m_rdata), .rresp(m_rresp), .rlast(m_rlast)
  );

  ysyx_2022040010_icache_refill #(.AXI_AW(32), .AXI_DW(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .miss_req(miss_req[1]), .miss_addr(m_addr), .miss_cache(m_cache), .miss_lru(m_lru),
    .miss_ready(miss_ready_o[1]), .refresh(refresh_o[1]), .refill_way(refill_way_o[1]),
    .cacheline_new(line_o[1]), .resp_valid(resp_valid_o[1]), .resp_inst(resp_inst_o[1]),
    .resp_err(resp_err_o[1]), .arvalid(arvalid_o[1]), .arready(arready[1]),
    .araddr(araddr_o[1]), .arid(arid_o[1]), .arlen(arlen_o[1]), .arsize(arsize_o[1]),
    .arburst(arburst_o[1]), .rvalid(rvalid[1]), .rready(rready_o[1]),
    .rdata(m_rdata[31:0]), .rresp(m_rresp), .rlast(m_rlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of the instance under test, set by the driver
  int          cur = 0;
  bit          chk_en = 1'b0;
  logic        e_ready, e_arvalid, e_rready, e_rv, e_refresh, e_err;
  logic [31:0] e_araddr, e_inst;
  logic [7:0]  e_arlen;
  logic [2:0]  e_arsize;
  logic        e_way       [2];
  logic        e_way_known [2];
  logic [63:0] e_line      [2];
  logic        e_line_known[2];

  // Snapshots taken by the driver for literal expectations
  int          fill_cyc, ar_cycles;
  logic [31:0] s_araddr, s_inst;
  logic [7:0]  s_arlen;
  logic        s_refresh, s_way, s_rv, s_err;
  logic [63:0] s_line;

  // Compare the active instance against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("miss_ready", 64'(miss_ready_o[cur]), 64'(e_ready));
      chk("arvalid", 64'(arvalid_o[cur]), 64'(e_arvalid));
      chk("rready", 64'(rready_o[cur]), 64'(e_rready));
      chk("resp_valid", 64'(resp_valid_o[cur]), 64'(e_rv));
      chk("refresh", 64'(refresh_o[cur]), 64'(e_refresh));
      chk("other_idle", 64'(miss_ready_o[1-cur]), 64'(1));
      if (e_arvalid) begin
        chk("araddr", 64'(araddr_o[cur]), 64'(e_araddr));
        chk("arlen", 64'(arlen_o[cur]), 64'(e_arlen));
        chk("arsize", 64'(arsize_o[cur]), 64'(e_arsize));
        chk("arburst", 64'(arburst_o[cur]), 64'(2'b01));
        chk("arid", 64'(arid_o[cur]), 64'(0));
      end
      if (e_rv) begin
        chk("resp_err", 64'(resp_err_o[cur]), 64'(e_err));
        chk("resp_inst", 64'(resp_inst_o[cur]), 64'(e_inst));
      end
      if (e_way_known[cur]) chk("refill_way", 64'(refill_way_o[cur]), 64'(e_way[cur]));
      if (e_line_known[cur]) chk("cacheline_new", line_o[cur], e_line[cur]);
    end
  end

  task automatic set_idle_exp();
    e_ready = 1'b1; e_arvalid = 1'b0; e_rready = 1'b0;
    e_rv = 1'b0; e_refresh = 1'b0; e_err = 1'b0;
  endtask

  task automatic after_reset_exp();
    set_idle_exp();
    for (int i = 0; i < 2; i++) begin
      e_way[i] = 1'b0; e_way_known[i] = 1'b1;
      e_line[i] = 64'd0; e_line_known[i] = 1'b1;
    end
  endtask

  task automatic noise(input int u, input bit en);
    if (en) begin
      miss_req[u] = 1'($urandom_range(0, 1));
      m_addr  = {$urandom, $urandom};
      m_cache = 1'($urandom_range(0, 1));
      m_lru   = 1'($urandom_range(0, 1));
    end else begin
      miss_req[u] = 1'b0;
    end
  endtask

  // One miss transaction; starts and ends at posedge+1 of an IDLE cycle.
  // rl_mode: 0 correct rlast, 1 rlast on every beat, 2 rlast never.
  task automatic run_txn(input int u, input logic [63:0] addr, input logic c, input logic lru,
                         input logic [63:0] data, input int ard, input logic [1:0] resp0,
                         input logic [1:0] resp1, input int rl_mode, input bit gaps,
                         input bit nz, input bit abort);
    int   dw;
    int   beats;
    int   cyc;
    int   b;
    bit   done;
    bit   lastbeat;
    logic err;
    logic [63:0] line;
    dw = (u == 1) ? 32 : 64;
    beats = 64 / dw;
    cur = u;
    set_idle_exp();
    miss_req[u] = 1'b1; m_addr = addr; m_cache = c; m_lru = lru;
    @(posedge clk); #1;
    cyc = 1;
    e_ready = 1'b0;
    e_way[u] = lru; e_way_known[u] = 1'b1; e_line_known[u] = 1'b0;
    e_arvalid = 1'b1;
    e_araddr = addr[31:0] & 32'hFFFF_FFF8;
    e_arlen = 8'(beats - 1);
    e_arsize = (dw == 32) ? 3'd2 : 3'd3;
    ar_cycles = 0;
    for (int k = 0; k <= ard; k++) begin
      arready[u] = (k == ard);
      noise(u, nz);
      if (k == 0) begin
        @(negedge clk);
        s_araddr = araddr_o[u]; s_arlen = arlen_o[u];
      end
      @(posedge clk); #1;
      cyc++; ar_cycles++;
    end
    arready[u] = 1'b0;
    e_arvalid = 1'b0; e_rready = 1'b1;
    err = 1'b0; line = 64'd0; b = 0; done = 1'b0;
    while (!done) begin
      int gap;
      gap = (gaps && ($urandom_range(0, 2) == 0)) ? $urandom_range(1, 2) : 0;
      for (int g = 0; g < gap; g++) begin
        rvalid[u] = 1'b0; noise(u, nz);
        @(posedge clk); #1; cyc++;
      end
      lastbeat = (b == beats - 1);
      rvalid[u] = 1'b1;
      noise(u, nz);
      m_rdata = (dw == 32) ? {$urandom, data[b*32 +: 32]} : data;
      m_rresp = (b == 0) ? resp0 : resp1;
      m_rlast = (rl_mode == 0) ? lastbeat : (rl_mode == 1);
      if (abort) begin
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_miss_ready", 64'(miss_ready_o[u]), 64'(1));
        chk("rst_arvalid", 64'(arvalid_o[u]), 64'(0));
        chk("rst_rready", 64'(rready_o[u]), 64'(0));
        chk("rst_refresh", 64'(refresh_o[u]), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid_o[u]), 64'(0));
        chk("rst_resp_err", 64'(resp_err_o[u]), 64'(0));
        chk("rst_line", line_o[u], 64'd0);
        chk("rst_resp_inst", 64'(resp_inst_o[u]), 64'(0));
        chk("rst_araddr", 64'(araddr_o[u]), 64'(0));
        chk("rst_refill_way", 64'(refill_way_o[u]), 64'(0));
        @(posedge clk); #1;
        rvalid[u] = 1'b0; miss_req[u] = 1'b0;
        rst = 1'b1;
        after_reset_exp();
        chk_en = 1'b1;
        return;
      end
      if ((m_rresp != 2'b00) || (m_rlast != lastbeat)) err = 1'b1;
      if (dw == 64) line = data;
      else line[b*32 +: 32] = data[b*32 +: 32];
      done = m_rlast || lastbeat;
      b++;
      @(posedge clk); #1; cyc++;
    end
    rvalid[u] = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    noise(u, nz);
    e_rready = 1'b0; e_rv = 1'b1;
    e_refresh = c & ~err;
    e_err = err;
    e_inst = err ? 32'd0 : (addr[2] ? line[63:32] : line[31:0]);
    if (!err) begin
      e_line[u] = line; e_line_known[u] = 1'b1;
    end
    fill_cyc = cyc;
    @(negedge clk);
    s_rv = resp_valid_o[u]; s_refresh = refresh_o[u]; s_way = refill_way_o[u];
    s_line = line_o[u]; s_inst = resp_inst_o[u]; s_err = resp_err_o[u];
    @(posedge clk); #1;
    miss_req[u] = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      miss_req[i] = 1'b0; arready[i] = 1'b0; rvalid[i] = 1'b0;
    end
    m_addr = 64'd0; m_cache = 1'b0; m_lru = 1'b0;
    m_rdata = 64'd0; m_rresp = 2'b00; m_rlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_miss_ready", 64'(miss_ready_o[i]), 64'(1));
      chk("reset_arvalid", 64'(arvalid_o[i]), 64'(0));
      chk("reset_line", line_o[i], 64'd0);
      chk("reset_araddr", 64'(araddr_o[i]), 64'(0));
    end
    rst = 1'b1;
    after_reset_exp();
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Cacheable zero-wait miss
    run_txn(0, 64'h0000_0000_8000_0104, 1'b1, 1'b1, 64'h1122334455667788, 0, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("t1_araddr", 64'(s_araddr), 64'h8000_0100);
    chk("t1_arlen", 64'(s_arlen), 64'd0);
    chk("t1_fill_cycle", 64'(fill_cyc), 64'd3);
    chk("t1_refresh", 64'(s_refresh), 64'd1);
    chk("t1_way", 64'(s_way), 64'd1);
    chk("t1_line", s_line, 64'h1122334455667788);
    chk("t1_inst", 64'(s_inst), 64'h11223344);

    // Uncached fetch
    run_txn(0, 64'h0000_0000_1000_0000, 1'b0, 1'b0, 64'hAAAABBBBCCCCDDDD, 0, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("t2_inst", 64'(s_inst), 64'hCCCCDDDD);
    chk("t2_refresh", 64'(s_refresh), 64'd0);

    // 32-bit bus, arready delayed
    run_txn(1, 64'h0000_0000_8000_0200, 1'b1, 1'b0, 64'h1122334455667788, 2, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("t3_ar_cycles", 64'(ar_cycles), 64'd3);
    chk("t3_araddr", 64'(s_araddr), 64'h8000_0200);
    chk("t3_arlen", 64'(s_arlen), 64'd1);
    chk("t3_fill_cycle", 64'(fill_cyc), 64'd6);
    chk("t3_line", s_line, 64'h1122334455667788);

    // Slave error response
    run_txn(0, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 64'h0123456789ABCDEF, 0, 2'b10, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("t4_resp_valid", 64'(s_rv), 64'd1);
    chk("t4_resp_err", 64'(s_err), 64'd1);
    chk("t4_refresh", 64'(s_refresh), 64'd0);
    chk("t4_inst", 64'(s_inst), 64'd0);

    // Stray requests during the burst, then back-to-back request
    run_txn(1, 64'h0000_0000_8000_0abc, 1'b1, 1'b1, 64'hDEADBEEFCAFEF00D, 1, 2'b00, 2'b00, 0, 1'b1, 1'b1, 1'b0);
    run_txn(1, 64'h0000_0000_8000_0bc0, 1'b1, 1'b0, 64'h0F0E0D0C0B0A0908, 0, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("t5_fill_cycle", 64'(fill_cyc), 64'd4);

    // Reset during R with a beat pending, then a clean miss
    run_txn(0, 64'h0000_0000_8000_0300, 1'b1, 1'b1, 64'h5555AAAA5555AAAA, 0, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b1);
    run_txn(0, 64'h0000_0000_8000_0304, 1'b1, 1'b0, 64'h8765432112345678, 0, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("t6_fill_cycle", 64'(fill_cyc), 64'd3);
    chk("t6_refresh", 64'(s_refresh), 64'd1);
    chk("t6_inst", 64'(s_inst), 64'h87654321);

    // Randomized traffic on both bus widths
    for (int n = 0; n < 160; n++) begin
      int u;
      int rl;
      logic [1:0] r0, r1;
      u  = $urandom_range(0, 1);
      rl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      r0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(u, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, $urandom_range(0, 3), r0, r1, rl, 1'b1, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
